// File: rtl/pll_reconfig_ctrl_if.sv
// Configuration request bundle between system control and the PLL
// reconfiguration controller.
//
// Handshake: the master holds cfg_idsel/cfg_fbdsel/cfg_odsel stable while
// cfg_valid is high. A request is accepted on the rising clkin edge where
// cfg_valid & cfg_ready are both high. cfg_ready never depends on cfg_valid.
// A cfg_valid seen while cfg_ready is low is dropped; requests are not queued.
interface pll_reconfig_ctrl_if;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic [5:0] cfg_odsel;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (
    output cfg_idsel,
    output cfg_fbdsel,
    output cfg_odsel,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_idsel,
    input  cfg_fbdsel,
    input  cfg_odsel,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Gowin rPLL reconfiguration controller. Runs on the PLL reference clock,
// sequences PLL reset, applies dynamic divider codes, waits for a debounced
// lock with a bounded timeout and retry budget, and releases downstream reset.
module pll_reconfig_ctrl #(
  parameter int         RST_HOLD_CYC     = 64,
  parameter int         LOCK_TIMEOUT_CYC = 50000,
  parameter int         LOCK_STABLE_CYC  = 1024,
  parameter int         MAX_RETRY        = 3,
  parameter int         SYNC_STAGES      = 2,
  parameter logic [5:0] DEF_IDSEL        = 6'd0,
  parameter logic [5:0] DEF_FBDSEL       = 6'd0,
  parameter logic [5:0] DEF_ODSEL        = 6'd0,
  localparam int        RW               = $clog2(MAX_RETRY + 1)
) (
  input  logic                 clkin,
  input  logic                 reset,
  pll_reconfig_ctrl_if.slave   cfg,
  input  logic                 pll_lock,
  output logic                 pll_reset,
  output logic [5:0]           pll_idsel,
  output logic [5:0]           pll_fbdsel,
  output logic [5:0]           pll_odsel,
  output logic                 locked,
  output logic                 clk_rst,
  output logic                 fail,
  output logic [RW-1:0]        retry_cnt,
  output logic [2:0]           state
);

  localparam logic [2:0] S_RST_HOLD  = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  localparam int HW = $clog2(RST_HOLD_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [2:0]             state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [TW-1:0]          to_q, to_d;
  logic [SW-1:0]          stab_q, stab_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [5:0]             idsel_q, idsel_d;
  logic [5:0]             fbdsel_q, fbdsel_d;
  logic [5:0]             odsel_q, odsel_d;
  logic                   accept;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Status decodes straight from the state register so async reset forces them at once.
  assign pll_reset     = (state_q == S_RST_HOLD) || (state_q == S_FAIL);
  assign locked        = (state_q == S_RUN);
  assign clk_rst       = ~locked;
  assign fail          = (state_q == S_FAIL);
  assign cfg.cfg_ready = (state_q == S_RUN) || (state_q == S_FAIL);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign pll_idsel     = idsel_q;
  assign pll_fbdsel    = fbdsel_q;
  assign pll_odsel     = odsel_q;
  assign retry_cnt     = retry_q;
  assign state         = state_q;

  // Bring the asynchronous LOCK pin into the clkin domain.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  // Next-state logic; a config accept overrides whatever RUN/FAIL would do.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    to_d     = to_q;
    stab_d   = stab_q;
    retry_d  = retry_q;
    idsel_d  = idsel_q;
    fbdsel_d = fbdsel_q;
    odsel_d  = odsel_q;
    case (state_q)
      S_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT_LOCK;
          to_d    = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_WAIT_LOCK, S_STABLE: begin
        // Timeout spans WAIT_LOCK and STABLE so a bouncing lock cannot stall forever.
        if (to_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_RST_HOLD;
            hold_d  = '0;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          to_d = to_q + 1'b1;
          if (state_q == S_WAIT_LOCK) begin
            if (lock_s) begin
              state_d = S_STABLE;
              stab_d  = '0;
            end
          end else if (!lock_s) begin
            state_d = S_WAIT_LOCK;
          end else if (stab_q == STAB_LAST) begin
            state_d = S_RUN;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RST_HOLD;
          hold_d  = '0;
          retry_d = '0;
        end
      end
      S_FAIL: ;
      default: begin
        state_d = S_RST_HOLD;
        hold_d  = '0;
      end
    endcase
    if (accept) begin
      state_d  = S_RST_HOLD;
      hold_d   = '0;
      retry_d  = '0;
      idsel_d  = cfg.cfg_idsel;
      fbdsel_d = cfg.cfg_fbdsel;
      odsel_d  = cfg.cfg_odsel;
    end
  end

  // State, counters and divider code registers.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q  <= S_RST_HOLD;
      hold_q   <= '0;
      to_q     <= '0;
      stab_q   <= '0;
      retry_q  <= '0;
      idsel_q  <= DEF_IDSEL;
      fbdsel_q <= DEF_FBDSEL;
      odsel_q  <= DEF_ODSEL;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      stab_q   <= stab_d;
      retry_q  <= retry_d;
      idsel_q  <= idsel_d;
      fbdsel_q <= fbdsel_d;
      odsel_q  <= odsel_d;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl with short simulation parameters.
// Expected state transitions are queued as {edge, state, retry_cnt} when a
// scenario is set up and are popped by a monitor whenever the state changes.
module tb_pll_reconfig_ctrl;

  localparam logic [2:0] ST_RH   = 3'd0;
  localparam logic [2:0] ST_WL   = 3'd1;
  localparam logic [2:0] ST_SB   = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       locked, clk_rst, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [2:0]  prev_state = 3'd0;
  logic [20:0] exp_q[$];
  logic [20:0] exp_item;
  logic [5:0]  r_id, r_fb, r_od;

  pll_reconfig_ctrl_if cfg_bus();

  pll_reconfig_ctrl #(
    .RST_HOLD_CYC(4), .LOCK_TIMEOUT_CYC(20), .LOCK_STABLE_CYC(8),
    .MAX_RETRY(2), .SYNC_STAGES(2)
  ) dut (
    .clkin(clkin), .reset(reset), .cfg(cfg_bus), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_odsel(pll_odsel), .locked(locked), .clk_rst(clk_rst), .fail(fail),
    .retry_cnt(retry_cnt), .state(state)
  );

  // Clock and edge counter (edges since reset release).
  always #5 clkin = ~clkin;
  always @(posedge clkin or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_ev(input int c, input logic [2:0] s, input logic [1:0] r);
    exp_q.push_back({16'(c), s, r});
  endtask

  task automatic run_to(input int n);
    while (cyc < n) @(negedge clkin);
  endtask

  task automatic drive_cfg(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
    cfg_bus.cfg_idsel  = id;
    cfg_bus.cfg_fbdsel = fb;
    cfg_bus.cfg_odsel  = od;
    cfg_bus.cfg_valid  = 1'b1;
  endtask

  // Asynchronous reset between clock edges, with the reset-state checks.
  task automatic do_reset();
    @(negedge clkin);
    #2;
    reset = 1'b1;
    pll_lock = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(ST_RH));
    chk("rst_codes", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'd0);
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_locked", 32'({locked, clk_rst}), 32'b01);
    chk("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clkin);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every state change must match the next queued transition.
  always @(negedge clkin) begin
    if (reset) begin
      prev_state = state;
    end else if (state != prev_state) begin
      chk("trans_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        chk("trans", 32'({16'(cyc), state, retry_cnt}), 32'(exp_item));
      end
      prev_state = state;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_idsel  = 6'd0;
    cfg_bus.cfg_fbdsel = 6'd0;
    cfg_bus.cfg_odsel  = 6'd0;

    // Bring-up with lock arriving before edge 10.
    do_reset();
    exp_ev(4, ST_WL, 0); exp_ev(12, ST_SB, 0); exp_ev(20, ST_RUN, 0);
    run_to(3);  chk("bu_hold_last", 32'(pll_reset), 32'd1);
    run_to(4);  chk("bu_hold_released", 32'(pll_reset), 32'd0);
    run_to(9);  pll_lock = 1'b1;
    run_to(19); chk("bu_not_yet_locked", 32'(locked), 32'd0);
    run_to(21);
    chk("bu_locked", 32'({locked, clk_rst, cfg_bus.cfg_ready}), 32'b101);
    chk("bu_q_empty", 32'(exp_q.size()), 32'd0);

    // Reconfigure while running.
    exp_ev(23, ST_RH, 0); exp_ev(27, ST_WL, 0); exp_ev(28, ST_SB, 0); exp_ev(36, ST_RUN, 0);
    run_to(22); drive_cfg(6'h3B, 6'h3E, 6'h30);
    run_to(23); cfg_bus.cfg_valid = 1'b0;
    chk("rc_codes", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'h3B, 6'h3E, 6'h30}));
    chk("rc_status", 32'({pll_reset, locked, clk_rst, cfg_bus.cfg_ready}), 32'b1010);
    run_to(37);
    chk("rc_relocked", 32'(locked), 32'd1);

    // Config accept on the same edge the synced lock drops.
    pll_lock = 1'b0;
    r_id = 6'($urandom_range(1, 63));
    r_fb = 6'($urandom_range(1, 63));
    r_od = 6'($urandom_range(1, 63));
    exp_ev(40, ST_RH, 0); exp_ev(44, ST_WL, 0);
    run_to(39); drive_cfg(r_id, r_fb, r_od);
    run_to(40); cfg_bus.cfg_valid = 1'b0;
    chk("sim_codes", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({r_id, r_fb, r_od}));
    chk("sim_retry", 32'(retry_cnt), 32'd0);
    run_to(45);
    chk("sim_q_empty", 32'(exp_q.size()), 32'd0);

    // Async reset in WAIT_LOCK with non-default codes (checked inside do_reset).
    run_to(50);
    chk("mid_state_wait", 32'(state), 32'(ST_WL));
    do_reset();

    // Bouncing lock in STABLE still times out from the first WAIT_LOCK entry.
    exp_ev(4, ST_WL, 0); exp_ev(12, ST_SB, 0); exp_ev(20, ST_WL, 0);
    exp_ev(23, ST_SB, 0); exp_ev(24, ST_RH, 1);
    run_to(9);  pll_lock = 1'b1;
    run_to(17); pll_lock = 1'b0;
    run_to(20); pll_lock = 1'b1;
    run_to(21);
    chk("bn_locked_low", 32'(locked), 32'd0);
    chk("bn_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    drive_cfg(6'h11, 6'h22, 6'h33);
    run_to(23); cfg_bus.cfg_valid = 1'b0;
    chk("bn_cfg_ignored", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'd0);
    run_to(25);
    chk("bn_retry", 32'(retry_cnt), 32'd1);
    chk("bn_q_empty", 32'(exp_q.size()), 32'd0);

    // No lock ever: three attempts then FAIL.
    do_reset();
    exp_ev(4, ST_WL, 0);  exp_ev(24, ST_RH, 1); exp_ev(28, ST_WL, 1);
    exp_ev(48, ST_RH, 2); exp_ev(52, ST_WL, 2); exp_ev(72, ST_FAIL, 2);
    run_to(71); chk("nl_not_failed", 32'(fail), 32'd0);
    run_to(74);
    chk("nl_fail", 32'({fail, pll_reset, cfg_bus.cfg_ready, locked}), 32'b1110);
    chk("nl_retry", 32'(retry_cnt), 32'd2);

    // Recover from FAIL with a new config.
    exp_ev(75, ST_RH, 0); exp_ev(79, ST_WL, 0); exp_ev(82, ST_SB, 0); exp_ev(90, ST_RUN, 0);
    drive_cfg(6'h15, 6'h2A, 6'h07);
    run_to(75); cfg_bus.cfg_valid = 1'b0;
    chk("fr_fail_clear", 32'({fail, pll_reset, cfg_bus.cfg_ready}), 32'b010);
    chk("fr_retry", 32'(retry_cnt), 32'd0);
    chk("fr_codes", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'h15, 6'h2A, 6'h07}));
    run_to(79); pll_lock = 1'b1;
    run_to(91);
    chk("fr_locked", 32'({locked, clk_rst}), 32'b10);
    chk("fr_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
